read_address: RTL and testbench
===============================

// Module: read_address
// PURPOSE
//  Read-side controller of the FIFO, opposite end of the write-pointer counter.
//  Keeps the read pointer, derives empty/level from the write pointer and drives the memory read address.
//  Prefetches one word into an output register with a valid/ready handshake toward the consumer.
//  Sits between the FIFO memory (combinational read port) and the downstream ALU datapath.
// PARAMETERS
//  MEMORY_DEPTH       4                         FIFO words; must be a power of 2 (>=2)
//  FIFO_ADDRESS_SIZE  $clog2(MEMORY_DEPTH)      memory address width A
//  DATA_WIDTH         8                         word width W
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst_n      in   1    reset, synchronous, active-low
//  flush      in   1    sync clear: discard FIFO contents and output word
//  w_ptr      in   A+1  write pointer from write side (MSB = wrap bit)
//  mem_rdata  in   W    memory word at r_addr, combinational
//  r_addr     out  A    memory read address = r_ptr[A-1:0]
//  r_ptr      out  A+1  read pointer (MSB = wrap bit), returned to write side for full
//  cr_max     out  1    r_ptr[A-1:0] == MEMORY_DEPTH-1 (next pop wraps address)
//  empty      out  1    w_ptr == r_ptr (no word left in memory)
//  level      out  A+1  words in memory = (w_ptr - r_ptr) mod 2^(A+1); excludes output reg
//  rd_valid   out  1    rd_data holds a valid word
//  rd_data    out  W    output word
//  rd_ready   in   1    consumer accepts rd_data when rd_valid & rd_ready
//  ptr_err    out  1    sticky: level ever exceeded MEMORY_DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at edge): r_ptr=0, rd_valid=0, rd_data=0, ptr_err=0; flush/other inputs ignored.
//  State = rd_valid: OUT_EMPTY (0), OUT_FULL (1).
//  fetch = !empty & (!rd_valid | rd_ready)  (combinational).
//  On fetch: rd_data <= mem_rdata; r_ptr <= r_ptr+1 (mod 2^(A+1), natural wrap).
//  rd_valid next = fetch | (rd_valid & !rd_ready).
//   OUT_EMPTY -> OUT_FULL on fetch; else stay.
//   OUT_FULL: rd_ready & fetch -> stay (new word); rd_ready & !fetch -> OUT_EMPTY; !rd_ready -> hold.
//  rd_data stable while rd_valid & !rd_ready; not updated when no fetch.
//  Latency: first cycle empty=0 (w_ptr changed) -> rd_valid=1 next cycle.
//  Throughput: 1 word/cycle with rd_ready=1 and memory non-empty.
//  Wrap: r_addr wraps MEMORY_DEPTH-1 -> 0 and r_ptr MSB toggles on that pop; cr_max flags it.
//  empty/level/cr_max/r_addr are combinational from r_ptr, w_ptr; no registered lag.
//  flush (rst_n=1): r_ptr <= w_ptr, rd_valid <= 0; takes priority over fetch/handshake; ptr_err kept.
//  ptr_err set when level > MEMORY_DEPTH (write-side overrun); cleared only by reset.
//  Simultaneous w_ptr change and fetch: empty uses current w_ptr only; new word fetched next cycle.
//  Reset mid-transfer: pending rd_data dropped, rd_valid=0 next cycle regardless of rd_ready.
// TESTING (MEMORY_DEPTH=4, DATA_WIDTH=8)
//  Reset with w_ptr=0 -> r_ptr=0, empty=1, level=0, rd_valid=0, rd_data=0, ptr_err=0.
//  w_ptr 0->1, mem[0]=8'hA5, rd_ready=0 -> next cycle rd_valid=1, rd_data=A5, r_ptr=1; held 5 cycles.
//  w_ptr=4 (mem=11,22,33,44), rd_ready=1 -> rd_data 11,22,33,44 on 4 consecutive cycles, then rd_valid=0, empty=1.
//  Stream 8 words with w_ptr leading -> r_ptr 0..7->0, r_addr 0,1,2,3,0,1,2,3, cr_max at r_addr=3; data order kept.
//  r_ptr=1, w_ptr=3, rd_valid=1, flush=1 -> next cycle r_ptr=3, rd_valid=0, empty=1, level=0.
//  r_ptr=0, force w_ptr=5 -> level=5, ptr_err=1 next cycle and stays 1 until rst_n=0.

Source files
------------

// File: rtl/read_address.sv
// read_address: read-side controller of the FIFO.
//   Owns the read pointer and derives empty/level/cr_max from the write
//   pointer. It drives the memory read address and prefetches one word into
//   an output register. The consumer takes that word with a valid/ready
//   handshake.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             discard memory contents and the output word
//   w_ptr             write pointer from the write side (MSB = wrap bit)
//   mem_rdata         memory word at r_addr (combinational read port)
//   r_addr            memory read address
//   r_ptr             read pointer (MSB = wrap bit), returned to write side
//   cr_max            read address sits on the last slot (next pop wraps)
//   empty             no word left in memory
//   level             words in memory, excluding the output register
//   rd_valid/rd_data  output word and its valid flag
//   rd_ready          consumer accepts rd_data
//   ptr_err           sticky overrun flag (level ever exceeded depth)
module read_address #(
  parameter int MEMORY_DEPTH      = 4,
  parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
  parameter int DATA_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic [FIFO_ADDRESS_SIZE-1:0] r_addr,
  output logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
  output logic                         cr_max,
  output logic                         empty,
  output logic [FIFO_ADDRESS_SIZE:0]   level,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         rd_ready,
  output logic                         ptr_err
);

  localparam int A = FIFO_ADDRESS_SIZE;
  localparam logic [A:0]   DEPTH_L = (A+1)'(MEMORY_DEPTH);
  localparam logic [A-1:0] LAST_L  = A'(MEMORY_DEPTH-1);

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  out_state_t          state_q, state_d;
  logic [A:0]          r_ptr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                ptr_err_q;
  logic                fetch;

  // Pointer arithmetic is purely combinational so the write side sees no lag.
  assign r_ptr    = r_ptr_q;
  assign r_addr   = r_ptr_q[A-1:0];
  assign empty    = (w_ptr == r_ptr_q);
  assign level    = w_ptr - r_ptr_q;
  assign cr_max   = (r_ptr_q[A-1:0] == LAST_L);
  assign rd_valid = (state_q == OUT_FULL);
  assign rd_data  = rd_data_q;
  assign ptr_err  = ptr_err_q;

  // Pull a word whenever memory has one and the output register is free or
  // being drained this cycle.
  assign fetch = !empty && (!rd_valid || rd_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (fetch) state_d = OUT_FULL;
      OUT_FULL:  if (rd_ready && !fetch) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
    if (flush) state_d = OUT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= OUT_EMPTY;
      r_ptr_q   <= '0;
      rd_data_q <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Flush realigns to the writer and drops anything in flight.
      if (flush) begin
        r_ptr_q <= w_ptr;
      end else if (fetch) begin
        r_ptr_q   <= r_ptr_q + 1'b1;
        rd_data_q <= mem_rdata;
      end
      if (level > DEPTH_L) ptr_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_read_address.sv
module tb_read_address;

  logic       clk = 1'b0;
  logic       rst_n, flush, rd_ready;
  logic [2:0] w_ptr, r_ptr, level;
  logic [1:0] r_addr;
  logic [7:0] mem_rdata, rd_data;
  logic       cr_max, empty, rd_valid, ptr_err;
  logic [7:0] mem [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[r_addr];

  read_address #(.MEMORY_DEPTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_ptr(w_ptr),
    .mem_rdata(mem_rdata), .r_addr(r_addr), .r_ptr(r_ptr), .cr_max(cr_max),
    .empty(empty), .level(level), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .ptr_err(ptr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; w_ptr = 3'd0; flush = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) mem[k] = 8'h00;
    rst_n = 1'b0; flush = 1'b1; rd_ready = 1'b0; w_ptr = 3'd0;
    step();
    flush = 1'b0;
    step();
    // reset state
    chk("rst_r_ptr", r_ptr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ptr_err", ptr_err, 0);
    rst_n = 1'b1;

    // single word, consumer stalled: held for 5 cycles
    mem[0] = 8'hA5; w_ptr = 3'd1;
    #1 chk("one_empty_pre", empty, 0);
    step();
    chk("one_valid", rd_valid, 1);
    chk("one_data", rd_data, 8'hA5);
    chk("one_r_ptr", r_ptr, 1);
    chk("one_empty", empty, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", rd_valid, 1);
      chk("hold_data", rd_data, 8'hA5);
      chk("hold_r_ptr", r_ptr, 1);
    end
    rd_ready = 1'b1;
    step();
    chk("drain_valid", rd_valid, 0);

    // burst of 4 with consumer always ready
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    w_ptr = 3'd4; rd_ready = 1'b1;
    #1 chk("burst_level", level, 4);
    chk("burst_cr_max0", cr_max, 0);
    step(); chk("burst_d0", rd_data, 8'h11); chk("burst_v0", rd_valid, 1); chk("burst_p0", r_ptr, 1);
    step(); chk("burst_d1", rd_data, 8'h22); chk("burst_p1", r_ptr, 2);
    step(); chk("burst_d2", rd_data, 8'h33); chk("burst_p2", r_ptr, 3);
    step(); chk("burst_d3", rd_data, 8'h44); chk("burst_p3", r_ptr, 4); chk("burst_v3", rd_valid, 1);
    chk("burst_empty", empty, 1);
    step(); chk("burst_v_end", rd_valid, 0); chk("burst_empty_end", empty, 1);
    chk("burst_ptr_err", ptr_err, 0);

    // streaming 8 words across the address wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("strm_addr", r_addr, i % 4);
      chk("strm_r_ptr", r_ptr, i);
      chk("strm_cr_max", cr_max, (i % 4) == 3);
      mem[i % 4] = 8'h10 + 8'(i);
      w_ptr = 3'(i + 1);
      step();
      chk("strm_valid", rd_valid, 1);
      chk("strm_data", rd_data, 8'h10 + i);
    end
    chk("strm_r_ptr_wrap", r_ptr, 0);
    step();
    chk("strm_v_end", rd_valid, 0);
    chk("strm_empty_end", empty, 1);

    // flush with a word pending
    do_reset();
    rd_ready = 1'b0; w_ptr = 3'd3;
    step();
    chk("fl_pre_r_ptr", r_ptr, 1);
    chk("fl_pre_valid", rd_valid, 1);
    chk("fl_pre_level", level, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_r_ptr", r_ptr, 3);
    chk("fl_valid", rd_valid, 0);
    chk("fl_empty", empty, 1);
    chk("fl_level", level, 0);

    // write-side overrun sets the sticky error
    do_reset();
    rd_ready = 1'b0; w_ptr = 3'd5;
    #1 chk("ovr_level", level, 5);
    chk("ovr_err_pre", ptr_err, 0);
    step();
    chk("ovr_err", ptr_err, 1);
    w_ptr = 3'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ovr_err_sticky", ptr_err, 1);
    end
    chk("ovr_valid_pend", rd_valid, 1);
    // reset mid-transfer, flush ignored while in reset
    rst_n = 1'b0; flush = 1'b1; rd_ready = 1'b0;
    step();
    chk("rr_ptr_err", ptr_err, 0);
    chk("rr_valid", rd_valid, 0);
    chk("rr_data", rd_data, 0);
    chk("rr_r_ptr", r_ptr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
